// File: rtl/dsram_responder.sv
module dsram_responder #(
  parameter int ADDR_W    = 12,
  parameter int LAT       = 2,
  parameter int QDEPTH    = 4,
  parameter     INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  input  logic        stall_in
);

  localparam int            PW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int            CW    = $clog2(QDEPTH + 1);
  localparam logic [PW-1:0] PLAST = PW'(QDEPTH - 1);
  localparam logic [CW-1:0] CMAX  = CW'(QDEPTH);
  localparam logic [3:0]    TINIT = 4'(LAT - 1);

  logic [31:0]       r_mem [0:(1<<ADDR_W)-1];
  logic [PW-1:0]     r_rptr, r_wptr;
  logic [CW-1:0]     r_cnt;
  logic [QDEPTH-1:0] r_is_wr;
  logic [31:0]       r_snap  [QDEPTH];
  logic [3:0]        r_timer [QDEPTH];
  logic              r_data_ok;
  logic [31:0]       r_rdata;

  logic              w_pop;
  logic              w_acc;
  logic [ADDR_W-1:0] w_idx;
  logic              w_unused_addr;

  assign w_idx         = data_sram_addr[ADDR_W+1:2];
  assign w_unused_addr = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

  assign w_pop             = (r_cnt != '0) && (r_timer[r_rptr] == '0);
  assign data_sram_addr_ok = ~stall_in & ((r_cnt < CMAX) | w_pop);
  assign w_acc             = data_sram_req & data_sram_addr_ok;

  assign data_sram_data_ok = r_data_ok;
  assign data_sram_rdata   = r_rdata;

  always_ff @(posedge clk) begin
    if (w_acc && data_sram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_wstrb[b]) r_mem[w_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rptr    <= '0;
      r_wptr    <= '0;
      r_cnt     <= '0;
      r_is_wr   <= '0;
      r_data_ok <= 1'b0;
      r_rdata   <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        r_snap[i]  <= '0;
        r_timer[i] <= '0;
      end
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (r_timer[i] != '0) r_timer[i] <= r_timer[i] - 4'd1;
      end
      if (w_acc) begin
        r_is_wr[r_wptr] <= data_sram_wr;
        r_snap[r_wptr]  <= data_sram_wr ? 32'h0 : r_mem[w_idx];
        r_timer[r_wptr] <= TINIT;
        r_wptr          <= (r_wptr == PLAST) ? '0 : r_wptr + PW'(1);
      end
      r_data_ok <= w_pop;
      if (w_pop) begin
        r_rdata <= r_is_wr[r_rptr] ? 32'h0 : r_snap[r_rptr];
        r_rptr  <= (r_rptr == PLAST) ? '0 : r_rptr + PW'(1);
      end
      case ({w_acc, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_dsram_responder.sv
// Bench for dsram_responder: two instances (LAT=2/QDEPTH=4 and LAT=4/QDEPTH=2) run
// against a request-level reference model (due edge = accept edge + LAT).
module tb_dsram_responder;

   localparam int LAT0 = 2, QD0 = 4, LAT1 = 4, QD1 = 2;

   logic        clk = 1'b0;
   logic        resetn;
   logic [1:0]  req, wr, stall, aok, dok;
   logic [3:0]  wstrb [2];
   logic [31:0] addr [2], wdata [2], rdata [2];

   always #5 clk = ~clk;

   dsram_responder #(.ADDR_W(12), .LAT(LAT0), .QDEPTH(QD0), .INIT_FILE("")) u_dut0 (
      .clk(clk), .resetn(resetn),
      .data_sram_req(req[0]), .data_sram_wr(wr[0]), .data_sram_wstrb(wstrb[0]),
      .data_sram_addr(addr[0]), .data_sram_wdata(wdata[0]),
      .data_sram_addr_ok(aok[0]), .data_sram_data_ok(dok[0]), .data_sram_rdata(rdata[0]),
      .stall_in(stall[0]));

   dsram_responder #(.ADDR_W(12), .LAT(LAT1), .QDEPTH(QD1), .INIT_FILE("")) u_dut1 (
      .clk(clk), .resetn(resetn),
      .data_sram_req(req[1]), .data_sram_wr(wr[1]), .data_sram_wstrb(wstrb[1]),
      .data_sram_addr(addr[1]), .data_sram_wdata(wdata[1]),
      .data_sram_addr_ok(aok[1]), .data_sram_data_ok(dok[1]), .data_sram_rdata(rdata[1]),
      .stall_in(stall[1]));

   // reference model: word storage plus a list of pending responses per instance
   logic [31:0] rmem [2][4096];
   int          due  [2][256];
   logic [31:0] edat [2][256];
   int          hd [2], tl [2];
   logic [31:0] exp_rd [2];
   logic [1:0]  acc, obs_aok, obs_dok;
   logic [31:0] obs_rd [2];
   int          cyc = 0;
   int          checks = 0, errors = 0;

   task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s[%0d] observed %h expected %h", tag, i, obs, exp);
      end
   endtask

   task automatic tick();
      logic [1:0] pe;
      cyc++;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         int lat, qd, outst, w;
         logic ea;
         lat   = (i == 0) ? LAT0 : LAT1;
         qd    = (i == 0) ? QD0 : QD1;
         outst = tl[i] - hd[i];
         pe[i] = (outst > 0) && (due[i][hd[i] % 256] == cyc);
         ea    = !stall[i] && (outst < qd || pe[i]);
         obs_aok[i] = aok[i];
         chk("addr_ok", i, {31'b0, aok[i]}, {31'b0, ea});
         acc[i] = req[i] && ea;
         if (acc[i]) begin
            w = int'(addr[i][13:2]);
            due[i][tl[i] % 256] = cyc + lat;
            if (wr[i]) begin
               edat[i][tl[i] % 256] = 32'h0;
               for (int b = 0; b < 4; b++)
                  if (wstrb[i][b]) rmem[i][w][8*b +: 8] = wdata[i][8*b +: 8];
            end else begin
               edat[i][tl[i] % 256] = rmem[i][w];
            end
            tl[i]++;
         end
         if (pe[i]) begin
            exp_rd[i] = edat[i][hd[i] % 256];
            hd[i]++;
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         obs_dok[i] = dok[i];
         obs_rd[i]  = rdata[i];
         chk("data_ok", i, {31'b0, dok[i]}, {31'b0, pe[i]});
         chk("rdata", i, rdata[i], exp_rd[i]);
      end
   endtask

   task automatic drain();
      req = 2'b00;
      stall = 2'b00;
      for (int n = 0; n < 20; n++) begin
         if (hd[0] == tl[0] && hd[1] == tl[1]) break;
         tick();
      end
   endtask

   task automatic setreq(input int i, input logic w, input logic [3:0] s,
                         input logic [31:0] a, input logic [31:0] d);
      req[i] = 1'b1; wr[i] = w; wstrb[i] = s; addr[i] = a; wdata[i] = d;
   endtask

   initial begin
      int cnt, run, maxrun, k;
      logic [1:0] alog [40];
      logic [31:0] r;
      resetn = 1'b1;
      req = 2'b00; wr = 2'b00; stall = 2'b01;
      for (int i = 0; i < 2; i++) begin
         wstrb[i] = 4'h0; addr[i] = '0; wdata[i] = '0;
         hd[i] = 0; tl[i] = 0; exp_rd[i] = '0;
      end

      // reset state
      #2 resetn = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("rst_data_ok", i, {31'b0, dok[i]}, 32'h0);
         chk("rst_rdata", i, rdata[i], 32'h0);
      end
      chk("rst_addr_ok_stall", 0, {30'b0, aok}, 32'h2);
      stall = 2'b00;
      #1 chk("rst_addr_ok", 0, {30'b0, aok}, 32'h3);
      @(posedge clk);
      #1 resetn = 1'b1;

      // preload words 0..15 in both instances
      for (int i = 0; i < 2; i++) begin
         for (int w = 0; w < 16; w++) begin
            setreq(i, 1'b1, 4'hF, 32'(w * 4), $urandom());
            for (int n = 0; n < 20; n++) begin
               tick();
               if (acc[i]) break;
            end
         end
         req = 2'b00;
         drain();
      end

      // basic write then read of 0x100
      setreq(0, 1'b1, 4'hF, 32'h100, 32'h12345678);
      tick();
      setreq(0, 1'b0, 4'h0, 32'h100, 32'h0);
      tick();
      req = 2'b00;
      tick();
      chk("wr_resp_ok", 0, {31'b0, obs_dok[0]}, 32'h1);
      chk("wr_resp_rdata", 0, obs_rd[0], 32'h0);
      tick();
      chk("rd_resp_ok", 0, {31'b0, obs_dok[0]}, 32'h1);
      chk("rd_resp_rdata", 0, obs_rd[0], 32'h12345678);
      drain();

      // byte strobes
      setreq(0, 1'b1, 4'hF, 32'h200, 32'hAABBCCDD);
      tick();
      setreq(0, 1'b1, 4'b0101, 32'h200, 32'h11223344);
      tick();
      setreq(0, 1'b0, 4'h0, 32'h200, 32'h0);
      tick();
      req = 2'b00;
      tick();
      tick();
      chk("strobe_rdata", 0, obs_rd[0], 32'hAA22CC44);
      drain();

      // back-to-back streaming on instance 0
      cnt = 0; run = 0; maxrun = 0;
      for (int w = 0; w < 12; w++) begin
         if (w < 8) setreq(0, 1'b0, 4'h0, 32'(w * 4), 32'h0);
         else req[0] = 1'b0;
         tick();
         if (w < 8) cnt += int'(obs_aok[0]);
         run = obs_dok[0] ? run + 1 : 0;
         if (run > maxrun) maxrun = run;
      end
      chk("stream_addr_ok", 0, 32'(cnt), 32'd8);
      chk("stream_run", 0, 32'(maxrun), 32'd8);
      drain();

      // queue full on instance 1 (QDEPTH=2, LAT=4)
      k = 0;
      for (int n = 0; n < 40; n++) begin
         alog[n] = 2'b00;
         if (k == 6) break;
         setreq(1, 1'b0, 4'h0, 32'(k * 4), 32'h0);
         tick();
         alog[n] = {obs_dok[1], obs_aok[1]};
         if (acc[1]) k++;
      end
      req = 2'b00;
      chk("full_blocked", 1, {30'b0, alog[2]}, 32'h0);
      chk("full_pop_reopen", 1, {30'b0, alog[4]}, 32'h3);
      drain();

      // stall injection with two reads outstanding
      setreq(0, 1'b0, 4'h0, 32'h4, 32'h0);
      tick();
      setreq(0, 1'b0, 4'h0, 32'h8, 32'h0);
      tick();
      setreq(0, 1'b0, 4'h0, 32'hC, 32'h0);
      stall[0] = 1'b1;
      cnt = 0; run = 0;
      for (int n = 0; n < 3; n++) begin
         tick();
         cnt += int'(obs_dok[0]);
         run += int'(obs_aok[0]);
      end
      chk("stall_resp", 0, 32'(cnt), 32'd2);
      chk("stall_accept", 0, 32'(run), 32'd0);
      stall[0] = 1'b0;
      tick();
      drain();

      // reset mid-flight
      setreq(0, 1'b0, 4'h0, 32'h100, 32'h0);
      setreq(1, 1'b0, 4'h0, 32'h0, 32'h0);
      tick();
      setreq(0, 1'b0, 4'h0, 32'h4, 32'h0);
      setreq(1, 1'b0, 4'h0, 32'h4, 32'h0);
      tick();
      setreq(0, 1'b0, 4'h0, 32'h8, 32'h0);
      req[1] = 1'b0;
      tick();
      req = 2'b00;
      chk("pre_rst_data_ok", 0, {31'b0, obs_dok[0]}, 32'h1);
      stall = 2'b01;
      #2 resetn = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("midrst_data_ok", i, {31'b0, dok[i]}, 32'h0);
         chk("midrst_rdata", i, rdata[i], 32'h0);
         hd[i] = tl[i];
         exp_rd[i] = '0;
      end
      chk("midrst_addr_ok", 0, {30'b0, aok}, 32'h2);
      resetn = 1'b1;
      stall = 2'b00;
      for (int n = 0; n < 6; n++) tick();
      setreq(0, 1'b0, 4'h0, 32'h100, 32'h0);
      tick();
      req = 2'b00;
      tick();
      tick();
      chk("post_rst_rdata", 0, obs_rd[0], 32'h12345678);
      drain();

      // randomized traffic with aliased addresses and random stalls
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < 2; i++) begin
            r = $urandom();
            r[13:2] = 12'($urandom_range(0, 15));
            req[i]   = ($urandom_range(0, 3) != 0);
            wr[i]    = 1'($urandom_range(0, 1));
            wstrb[i] = 4'($urandom());
            addr[i]  = r;
            wdata[i] = $urandom();
            stall[i] = ($urandom_range(0, 7) == 0);
         end
         tick();
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
